mem_arb: RTL and testbench
==========================

# mem_arb

Two-requester arbiter that shares the single core memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It sits between the core's fetch/LSU request channels and the bus interface. Requests use valid/ready handshakes. Up to OUTS_DP requests may be outstanding, and in-order responses are routed back to the issuing requester through a source-ID FIFO.

## Interface
- AW, 32, address width
- DW, 32, data width
- OUTS_DP, 2, max outstanding requests (≥1); depth of source-ID FIFO
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_vld / ifu_req_rdy  in/out  1/1  IFU request handshake (read-only)
- ifu_req_addr  in  AW  IFU fetch address
- ifu_rsp_vld / ifu_rsp_rdy  out/in  1/1  IFU response handshake
- ifu_rsp_data  out  DW  fetch data; ifu_rsp_err  out  1  bus error
- lsu_req_vld / lsu_req_rdy  in/out  1/1  LSU request handshake
- lsu_req_addr  in  AW; lsu_req_wen  in  1  1 = write; lsu_req_wdata  in  DW; lsu_req_wstrb  in  DW/8
- lsu_rsp_vld / lsu_rsp_rdy  out/in  1/1; lsu_rsp_data  out  DW; lsu_rsp_err  out  1
- mem_req_vld / mem_req_rdy  out/in  1/1  shared memory request handshake
- mem_req_addr  out  AW; mem_req_wen  out  1; mem_req_wdata  out  DW; mem_req_wstrb  out  DW/8
- mem_rsp_vld / mem_rsp_rdy  in/out  1/1; mem_rsp_data  in  DW; mem_rsp_err  in  1

## Operation
- Request path is combinational mux of granted requester onto mem_req_*.
- IFU requests drive wen=0, wstrb=0, wdata=0.
- Arbitration FSM, states IDLE and HOLD:
  - IDLE: if the FIFO is not full and any requester is valid, grant. Sole requester wins. On conflict, grant goes to the requester not granted last (round-robin bit rr_last).
  - IDLE: mem_req_vld=1 with granted payload. If mem_req_rdy=1 (handshake), stay IDLE and update rr_last. If mem_req_rdy=0, go to HOLD and latch the grant.
  - HOLD: grant is frozen to the latched requester regardless of the other requester. Return to IDLE on handshake and update rr_last.
  - Requesters must hold valid/payload until ready (protocol rule). The arbiter never withdraws mem_req_vld once asserted.
- Granted requester's rdy = mem_req_rdy & ~fifo_full; the non-granted requester's rdy = 0.
- Source-ID FIFO (1 bit/entry, 0=IFU, 1=LSU), depth OUTS_DP, count 0..OUTS_DP:
  - Push on mem request handshake; pop on mem response handshake.
  - Full: mem_req_vld=0, both req_rdy=0. A pop in the same cycle does not bypass; the new request is accepted the next cycle.
  - Simultaneous push and pop at non-full: count unchanged, pointers both advance (wrap modulo OUTS_DP).
- Response routing uses the FIFO head:
  - ifu_rsp_vld = mem_rsp_vld & ~empty & head==0; lsu_rsp_vld likewise with head==1.
  - mem_rsp_rdy = ~empty & (head ? lsu_rsp_rdy : ifu_rsp_rdy).
  - rsp data/err are broadcast to both requesters.
  - Empty FIFO: mem_rsp_rdy=0 and both rsp_vld=0, so a stray response stalls and is not consumed.

## Timing
- Reset (rst=0): FSM=IDLE, rr_last=IFU (LSU wins the first conflict), FIFO count/pointers=0.
- Outputs after reset: mem_req_vld=0 unless a requester is valid; mem_rsp_rdy=0; ifu/lsu_rsp_vld=0.
- Reset asserted mid-transaction discards all outstanding IDs and any HOLD state immediately (asynchronous).
- Request latency 0 cycles (combinational pass-through). Back-to-back grants are possible every cycle.
- Response latency 0 cycles (combinational routing). A response can be returned in the same cycle as a new request from either source.
- The FIFO count is visible to the full check on the cycle after push.

## Test plan
- Single IFU read, addr 0x8000_0000, mem_req_rdy=1, response 0x0000_0013 one cycle later → mem_req_addr=0x8000_0000 with wen=0. ifu_rsp_data=0x13, lsu_rsp_vld stays 0.
- IFU and LSU both valid every cycle after reset, mem always ready → grants alternate LSU, IFU, LSU, IFU. Responses return in issue order to the matching ports.
- LSU write (addr 0x100, wdata 0xDEADBEEF, wstrb 0xF) granted with mem_req_rdy=0 for 3 cycles while IFU asserts valid → the grant stays on the LSU with stable payload. The IFU is granted the cycle after the LSU handshake.
- OUTS_DP=2: issue 2 requests with no responses → third request sees req_rdy=0 and mem_req_vld=0. Return one response → the third request is accepted the next cycle.
- mem_rsp_vld=1 with mem_rsp_err=1 while head=LSU and lsu_rsp_rdy=0 for 2 cycles → mem_rsp_rdy=0 for those cycles. lsu_rsp_err=1, then the pop occurs on the cycle lsu_rsp_rdy=1.
- Drive rst low with 2 outstanding requests and HOLD active → FIFO empty and FSM in IDLE. A later mem_rsp_vld is not accepted (mem_rsp_rdy=0).

Source files
------------

// File: rtl/mem_arb_if.sv
// Request/response channels shared by IFU, LSU, the arbiter and memory.
// slave = arbiter view; master = surrounding core/memory view.
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_vld;
  logic          ifu_req_rdy;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_rsp_vld;
  logic          ifu_rsp_rdy;
  logic [DW-1:0] ifu_rsp_data;
  logic          ifu_rsp_err;

  logic            lsu_req_vld;
  logic            lsu_req_rdy;
  logic [AW-1:0]   lsu_req_addr;
  logic            lsu_req_wen;
  logic [DW-1:0]   lsu_req_wdata;
  logic [DW/8-1:0] lsu_req_wstrb;
  logic            lsu_rsp_vld;
  logic            lsu_rsp_rdy;
  logic [DW-1:0]   lsu_rsp_data;
  logic            lsu_rsp_err;

  logic            mem_req_vld;
  logic            mem_req_rdy;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wen;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_rsp_vld;
  logic            mem_rsp_rdy;
  logic [DW-1:0]   mem_rsp_data;
  logic            mem_rsp_err;

  modport slave (
    input  ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
    output ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err,
    input  lsu_req_vld, lsu_req_addr, lsu_req_wen,
    input  lsu_req_wdata, lsu_req_wstrb, lsu_rsp_rdy,
    output lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data, lsu_rsp_err,
    output mem_req_vld, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wstrb, mem_rsp_rdy,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data, mem_rsp_err
  );

  modport master (
    output ifu_req_vld, ifu_req_addr, ifu_rsp_rdy,
    input  ifu_req_rdy, ifu_rsp_vld, ifu_rsp_data, ifu_rsp_err,
    output lsu_req_vld, lsu_req_addr, lsu_req_wen,
    output lsu_req_wdata, lsu_req_wstrb, lsu_rsp_rdy,
    input  lsu_req_rdy, lsu_rsp_vld, lsu_rsp_data, lsu_rsp_err,
    input  mem_req_vld, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wstrb, mem_rsp_rdy,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data, mem_rsp_err
  );
endinterface

// File: rtl/mem_arb.sv
// IFU/LSU arbiter onto one memory port; in-order responses are
// steered back to their issuer through a source-ID FIFO.
module mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int OUTS_DP = 2
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);
  localparam int CW = $clog2(OUTS_DP + 1);
  localparam int PW = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_nx;
  logic   gnt, gnt_q, rr_last;
  logic   req_vld, fire, pop;

  logic [OUTS_DP-1:0] ids;
  logic [PW-1:0]      wptr, rptr;
  logic [CW-1:0]      cnt;
  logic               full, empty, head;

  logic [AW-1:0]   req_addr;
  logic            req_wen;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == CW'(OUTS_DP));
  assign empty = (cnt == '0);
  assign head  = ids[rptr];

  always_comb begin
    state_nx = state;
    gnt      = gnt_q;
    req_vld  = 1'b0;
    unique case (state)
      IDLE: begin
        // rr_last names the last winner; the other side wins a tie
        if (bus.ifu_req_vld & bus.lsu_req_vld) gnt = ~rr_last;
        else gnt = bus.lsu_req_vld;
        req_vld = ~full & (bus.ifu_req_vld | bus.lsu_req_vld);
        if (req_vld & ~bus.mem_req_rdy) state_nx = HOLD;
      end
      HOLD: begin
        req_vld = ~full;
        if (req_vld & bus.mem_req_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fire = req_vld & bus.mem_req_rdy;

  always_comb begin
    req_addr  = bus.ifu_req_addr;
    req_wen   = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    if (gnt) begin
      req_addr  = bus.lsu_req_addr;
      req_wen   = bus.lsu_req_wen;
      req_wdata = bus.lsu_req_wdata;
      req_wstrb = bus.lsu_req_wstrb;
    end
  end

  assign bus.mem_req_vld   = req_vld;
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_req_wen   = req_wen;
  assign bus.mem_req_wdata = req_wdata;
  assign bus.mem_req_wstrb = req_wstrb;
  assign bus.ifu_req_rdy   = fire & ~gnt;
  assign bus.lsu_req_rdy   = fire & gnt;

  assign bus.ifu_rsp_vld  = bus.mem_rsp_vld & ~empty & ~head;
  assign bus.lsu_rsp_vld  = bus.mem_rsp_vld & ~empty & head;
  assign bus.mem_rsp_rdy  = ~empty &
                            (head ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy);
  assign bus.ifu_rsp_data = bus.mem_rsp_data;
  assign bus.ifu_rsp_err  = bus.mem_rsp_err;
  assign bus.lsu_rsp_data = bus.mem_rsp_data;
  assign bus.lsu_rsp_err  = bus.mem_rsp_err;

  assign pop = bus.mem_rsp_vld & bus.mem_rsp_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      rr_last <= 1'b0;
    end else begin
      state <= state_nx;
      gnt_q <= gnt;
      if (fire) rr_last <= gnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ids  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (fire) begin
        ids[wptr] <= gnt;
        wptr      <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      unique case ({fire, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus a randomized run
// against a queue-based model of grants and response routing.
module tb_mem_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mem_arb_if #(.AW(32), .DW(32)) bus ();

  mem_arb #(.AW(32), .DW(32), .OUTS_DP(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic clr();
    bus.ifu_req_vld   = 1'b0;
    bus.ifu_req_addr  = '0;
    bus.ifu_rsp_rdy   = 1'b0;
    bus.lsu_req_vld   = 1'b0;
    bus.lsu_req_addr  = '0;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_req_wdata = '0;
    bus.lsu_req_wstrb = '0;
    bus.lsu_rsp_rdy   = 1'b0;
    bus.mem_req_rdy   = 1'b0;
    bus.mem_rsp_vld   = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic xfer_ifu(input logic [31:0] a);
    step();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = a;
    bus.mem_req_rdy  = 1'b1;
  endtask

  task automatic xfer_lsu(input logic [31:0] a);
    step();
    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_addr = a;
    bus.mem_req_rdy  = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.mem_rsp_vld = 1'b1;
      bus.ifu_rsp_rdy = 1'b1;
      bus.lsu_rsp_rdy = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr();
    bus.mem_rsp_vld = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    ncmp++;
    if ({bus.mem_req_vld, bus.mem_rsp_rdy,
         bus.ifu_rsp_vld, bus.lsu_rsp_vld} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_outs got %b want 0000",
               {bus.mem_req_vld, bus.mem_rsp_rdy,
                bus.ifu_rsp_vld, bus.lsu_rsp_vld});
    end
    bus.ifu_req_vld = 1'b1;
    #1;
    ncmp++;
    if (bus.mem_req_vld !== 1'b1) begin
      nerr++;
      $display("FAIL reset_req_vld got %b want 1", bus.mem_req_vld);
    end
    @(negedge clk);
    clr();
    rst = 1'b1;
  endtask

  task automatic test_single_ifu();
    do_reset();
    step();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h8000_0000;
    bus.mem_req_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_req_vld, bus.mem_req_addr, bus.mem_req_wen,
         bus.ifu_req_rdy, bus.lsu_req_rdy} !==
        {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL single_req got v%b a%h w%b r%b%b want v1 a80000000 w0 r10",
               bus.mem_req_vld, bus.mem_req_addr, bus.mem_req_wen,
               bus.ifu_req_rdy, bus.lsu_req_rdy);
    end
    step();
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = 32'h0000_0013;
    bus.ifu_rsp_rdy  = 1'b1;
    bus.lsu_rsp_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.ifu_rsp_vld, bus.ifu_rsp_data, bus.lsu_rsp_vld,
         bus.mem_rsp_rdy} !== {1'b1, 32'h13, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL single_rsp got v%b d%h l%b r%b want v1 d00000013 l0 r1",
               bus.ifu_rsp_vld, bus.ifu_rsp_data, bus.lsu_rsp_vld,
               bus.mem_rsp_rdy);
    end
  endtask

  task automatic test_rr();
    bit exp[$];
    bit g, s;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      bus.ifu_req_vld  = (k < 4);
      bus.lsu_req_vld  = (k < 4);
      bus.ifu_req_addr = 32'h1000 + 32'(k * 4);
      bus.lsu_req_addr = 32'h2000 + 32'(k * 4);
      bus.mem_req_rdy  = 1'b1;
      bus.ifu_rsp_rdy  = 1'b1;
      bus.lsu_rsp_rdy  = 1'b1;
      bus.mem_rsp_vld  = (k > 0);
      bus.mem_rsp_data = 32'hA0 + 32'(k);
      #1;
      if (k < 4) begin
        g = (k % 2 == 0);
        ncmp++;
        if ({bus.lsu_req_rdy, bus.ifu_req_rdy} !== {g, ~g}) begin
          nerr++;
          $display("FAIL rr_grant%0d got lsu/ifu %b%b want %b%b", k,
                   bus.lsu_req_rdy, bus.ifu_req_rdy, g, ~g);
        end
        exp.push_back(g);
      end
      if (k > 0) begin
        s = exp.pop_front();
        ncmp++;
        if ({bus.lsu_rsp_vld, bus.ifu_rsp_vld} !== {s, ~s}) begin
          nerr++;
          $display("FAIL rr_route%0d got lsu/ifu %b%b want %b%b", k,
                   bus.lsu_rsp_vld, bus.ifu_rsp_vld, s, ~s);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    xfer_lsu(32'h40);
    drain(1);
    for (int k = 0; k < 5; k++) begin
      step();
      bus.lsu_req_vld   = (k < 4);
      bus.lsu_req_addr  = 32'h100;
      bus.lsu_req_wen   = 1'b1;
      bus.lsu_req_wdata = 32'hDEAD_BEEF;
      bus.lsu_req_wstrb = 4'hF;
      bus.ifu_req_vld   = (k > 0);
      bus.ifu_req_addr  = 32'h300;
      bus.mem_req_rdy   = (k >= 3);
      #1;
      if (k < 4) begin
        ncmp++;
        if ({bus.mem_req_vld, bus.mem_req_addr, bus.mem_req_wen,
             bus.mem_req_wdata, bus.mem_req_wstrb, bus.ifu_req_rdy,
             bus.lsu_req_rdy} !== {1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF,
             4'hF, 1'b0, (k == 3)}) begin
          nerr++;
          $display("FAIL hold%0d got a%h w%b d%h s%h r%b%b want a100 w1 deadbeef f r0%b",
                   k, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata,
                   bus.mem_req_wstrb, bus.ifu_req_rdy, bus.lsu_req_rdy,
                   (k == 3));
        end
      end else begin
        ncmp++;
        if ({bus.ifu_req_rdy, bus.mem_req_addr, bus.mem_req_wen} !==
            {1'b1, 32'h300, 1'b0}) begin
          nerr++;
          $display("FAIL hold_next got r%b a%h w%b want r1 a300 w0",
                   bus.ifu_req_rdy, bus.mem_req_addr, bus.mem_req_wen);
        end
      end
    end
    drain(2);
  endtask

  task automatic test_full();
    do_reset();
    xfer_ifu(32'h0);
    xfer_lsu(32'h4);
    step();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h8;
    bus.mem_req_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_req_vld, bus.ifu_req_rdy, bus.lsu_req_rdy} !== 3'b000) begin
      nerr++;
      $display("FAIL full_block got %b want 000",
               {bus.mem_req_vld, bus.ifu_req_rdy, bus.lsu_req_rdy});
    end
    step();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h8;
    bus.mem_req_rdy  = 1'b1;
    bus.mem_rsp_vld  = 1'b1;
    bus.mem_rsp_data = 32'h55;
    bus.ifu_rsp_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_rsp_rdy, bus.ifu_rsp_vld, bus.mem_req_vld} !== 3'b110) begin
      nerr++;
      $display("FAIL full_nobypass got %b want 110",
               {bus.mem_rsp_rdy, bus.ifu_rsp_vld, bus.mem_req_vld});
    end
    step();
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h8;
    bus.mem_req_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_req_vld, bus.ifu_req_rdy} !== 2'b11) begin
      nerr++;
      $display("FAIL full_accept got %b want 11",
               {bus.mem_req_vld, bus.ifu_req_rdy});
    end
    drain(2);
  endtask

  task automatic test_rsp_stall();
    do_reset();
    xfer_lsu(32'h10);
    for (int k = 0; k < 3; k++) begin
      step();
      bus.mem_rsp_vld  = 1'b1;
      bus.mem_rsp_err  = 1'b1;
      bus.mem_rsp_data = 32'hBAD;
      bus.ifu_rsp_rdy  = 1'b1;
      bus.lsu_rsp_rdy  = (k == 2);
      #1;
      ncmp++;
      if ({bus.mem_rsp_rdy, bus.lsu_rsp_vld, bus.lsu_rsp_err,
           bus.ifu_rsp_vld} !== {(k == 2), 3'b110}) begin
        nerr++;
        $display("FAIL stall%0d got %b want %b", k,
                 {bus.mem_rsp_rdy, bus.lsu_rsp_vld, bus.lsu_rsp_err,
                  bus.ifu_rsp_vld}, {(k == 2), 3'b110});
      end
    end
    step();
    bus.mem_rsp_vld = 1'b1;
    bus.ifu_rsp_rdy = 1'b1;
    bus.lsu_rsp_rdy = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_rsp_rdy, bus.lsu_rsp_vld} !== 2'b00) begin
      nerr++;
      $display("FAIL stall_popped got %b want 00",
               {bus.mem_rsp_rdy, bus.lsu_rsp_vld});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    xfer_ifu(32'h20);
    for (int k = 0; k < 2; k++) begin
      step();
      bus.lsu_req_vld  = 1'b1;
      bus.lsu_req_addr = 32'h24;
    end
    #2;
    rst = 1'b0;
    bus.mem_rsp_vld = 1'b1;
    bus.ifu_rsp_rdy = 1'b1;
    bus.lsu_rsp_rdy = 1'b1;
    #1;
    ncmp++;
    if ({bus.mem_rsp_rdy, bus.ifu_rsp_vld, bus.lsu_rsp_vld} !== 3'b000) begin
      nerr++;
      $display("FAIL rstmid_rsp got %b want 000",
               {bus.mem_rsp_rdy, bus.ifu_rsp_vld, bus.lsu_rsp_vld});
    end
    step();
    rst = 1'b1;
    bus.ifu_req_vld  = 1'b1;
    bus.ifu_req_addr = 32'h30;
    bus.mem_req_rdy  = 1'b1;
    bus.mem_rsp_vld  = 1'b1;
    bus.ifu_rsp_rdy  = 1'b1;
    bus.lsu_rsp_rdy  = 1'b1;
    #1;
    ncmp++;
    if ({bus.ifu_req_rdy, bus.mem_req_addr, bus.mem_rsp_rdy} !==
        {1'b1, 32'h30, 1'b0}) begin
      nerr++;
      $display("FAIL rstmid_idle got r%b a%h m%b want r1 a30 m0",
               bus.ifu_req_rdy, bus.mem_req_addr, bus.mem_rsp_rdy);
    end
    step();
    bus.lsu_req_vld  = 1'b1;
    bus.lsu_req_addr = 32'h34;
    bus.mem_req_rdy  = 1'b1;
    #1;
    ncmp++;
    if (bus.lsu_req_rdy !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_count got %b want 1", bus.lsu_req_rdy);
    end
    drain(2);
  endtask

  task automatic test_random();
    bit          q[$];
    bit          rr, lock, lwho, ip, lp, rp;
    bit          full, ev, eg, efire, ne, head, erdy;
    logic [31:0] ia, la, lwd, rd;
    logic        lw, re;
    logic [3:0]  lws;
    rr = 1'b0; lock = 1'b0; lwho = 1'b0;
    ip = 1'b0; lp = 1'b0; rp = 1'b0;
    ia = '0; la = '0; lwd = '0; rd = '0;
    lw = 1'b0; re = 1'b0; lws = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step();
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1;
        ia = $urandom;
      end
      if (!lp && $urandom_range(0, 1) == 1) begin
        lp  = 1'b1;
        la  = $urandom;
        lw  = 1'($urandom_range(0, 1));
        lwd = $urandom;
        lws = 4'($urandom_range(0, 15));
      end
      if (!rp && q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rp = 1'b1;
        rd = $urandom;
        re = ($urandom_range(0, 3) == 0);
      end
      bus.ifu_req_vld   = ip;
      bus.ifu_req_addr  = ia;
      bus.lsu_req_vld   = lp;
      bus.lsu_req_addr  = la;
      bus.lsu_req_wen   = lw;
      bus.lsu_req_wdata = lwd;
      bus.lsu_req_wstrb = lws;
      bus.mem_req_rdy   = ($urandom_range(0, 2) != 0);
      bus.mem_rsp_vld   = rp;
      bus.mem_rsp_data  = rd;
      bus.mem_rsp_err   = re;
      bus.ifu_rsp_rdy   = ($urandom_range(0, 3) != 0);
      bus.lsu_rsp_rdy   = ($urandom_range(0, 3) != 0);
      #1;
      full  = (q.size() == 2);
      ev    = !full && (ip || lp);
      eg    = lock ? lwho : ((ip && lp) ? ~rr : lp);
      efire = ev && bus.mem_req_rdy;
      ne    = (q.size() > 0);
      head  = ne ? q[0] : 1'b0;
      erdy  = ne && (head ? bus.lsu_rsp_rdy : bus.ifu_rsp_rdy);
      ncmp++;
      if ({bus.mem_req_vld, bus.ifu_req_rdy, bus.lsu_req_rdy} !==
          {ev, efire && !eg, efire && eg}) begin
        nerr++;
        $display("FAIL rnd_req c%0d got %b want %b", c,
                 {bus.mem_req_vld, bus.ifu_req_rdy, bus.lsu_req_rdy},
                 {ev, efire && !eg, efire && eg});
      end
      if (ev) begin
        ncmp++;
        if ({bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata,
             bus.mem_req_wstrb} !== (eg ? {la, lw, lwd, lws}
                                        : {ia, 1'b0, 32'h0, 4'h0})) begin
          nerr++;
          $display("FAIL rnd_payload c%0d got a%h w%b d%h s%h gnt%b", c,
                   bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata,
                   bus.mem_req_wstrb, eg);
        end
      end
      ncmp++;
      if ({bus.ifu_rsp_vld, bus.lsu_rsp_vld, bus.mem_rsp_rdy} !==
          {rp && ne && !head, rp && ne && head, erdy}) begin
        nerr++;
        $display("FAIL rnd_rsp c%0d got %b want %b", c,
                 {bus.ifu_rsp_vld, bus.lsu_rsp_vld, bus.mem_rsp_rdy},
                 {rp && ne && !head, rp && ne && head, erdy});
      end
      if (rp) begin
        ncmp++;
        if ({bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_data,
             bus.lsu_rsp_err} !== {rd, re, rd, re}) begin
          nerr++;
          $display("FAIL rnd_rdata c%0d got %h/%b %h/%b want %h/%b", c,
                   bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_data,
                   bus.lsu_rsp_err, rd, re);
        end
      end
      @(posedge clk);
      if (rp && erdy) begin
        void'(q.pop_front());
        rp = 1'b0;
      end
      if (efire) begin
        q.push_back(eg);
        rr   = eg;
        lock = 1'b0;
        if (eg) lp = 1'b0;
        else ip = 1'b0;
      end else if (ev) begin
        lock = 1'b1;
        lwho = eg;
      end
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_single_ifu();
    test_rr();
    test_hold();
    test_full();
    test_rsp_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
